// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: physical tag / datapath widths, the
// source-operand record and the issue-queue entry record.
package ooo_pkg;

  localparam int unsigned TAG_W  = 6;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned INST_W = 32;

  typedef struct packed {
    logic              ready;
    logic [TAG_W-1:0]  tag;
    logic [XLEN-1:0]   value;
  } src_operand_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic [TAG_W-1:0]  rd_tag;
    src_operand_t      src1;
    src_operand_t      src2;
  } iq_entry_t;

endpackage

// File: rtl/iq_operand_wakeup.sv
// Combinational CDB wakeup for one source operand.
// Ports:
//   op_i        operand as currently held
//   cdb_valid_i / cdb_tag_i / cdb_value_i  writeback broadcast
//   op_o        operand after applying a matching broadcast
module iq_operand_wakeup
  import ooo_pkg::*;
(
  input  src_operand_t     op_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [XLEN-1:0]  cdb_value_i,
  output src_operand_t     op_o
);

  // Only a still-waiting operand may capture; a ready value is never overwritten.
  always_comb begin
    op_o = op_i;
    if (!op_i.ready && cdb_valid_i && (op_i.tag == cdb_tag_i)) begin
      op_o.ready = 1'b1;
      op_o.value = cdb_value_i;
    end
  end

endmodule

// File: rtl/arith_issue_queue.sv
// Collapsing reservation station in front of the arith execution unit.
// Holds dispatched ALU ops until both operands are ready (capturing them
// from the CDB), then issues the oldest ready entry, one per cycle.
// TAG_W / XLEN come from ooo_pkg; DEPTH is a power of two >= 2.
// Optional macro ARITH_IQ_BYPASS_EN: an empty queue sends a fully-ready
// dispatch straight to the issue outputs (1-cycle latency, never stored).
// Ports:
//   clk_i, reset_i (sync, active high), flush_i
//   dispatch_*       dispatch request / operand state / dest tag, dispatch_ready_o
//   cdb_*            writeback broadcast
//   arith_request_o, pc_o, inst_o, rs1_value_o, rs2_value_o, rd_tag_o  issue
//   count_o          occupied entries
module arith_issue_queue
  import ooo_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       dispatch_valid_i,
  output logic                       dispatch_ready_o,
  input  logic [XLEN-1:0]            dispatch_pc_i,
  input  logic [INST_W-1:0]          dispatch_inst_i,
  input  logic                       dispatch_rs1_ready_i,
  input  logic [TAG_W-1:0]           dispatch_rs1_tag_i,
  input  logic [XLEN-1:0]            dispatch_rs1_value_i,
  input  logic                       dispatch_rs2_ready_i,
  input  logic [TAG_W-1:0]           dispatch_rs2_tag_i,
  input  logic [XLEN-1:0]            dispatch_rs2_value_i,
  input  logic [TAG_W-1:0]           dispatch_rd_tag_i,
  input  logic                       cdb_valid_i,
  input  logic [TAG_W-1:0]           cdb_tag_i,
  input  logic [XLEN-1:0]            cdb_value_i,
  output logic                       arith_request_o,
  output logic [XLEN-1:0]            pc_o,
  output logic [INST_W-1:0]          inst_o,
  output logic [XLEN-1:0]            rs1_value_o,
  output logic [XLEN-1:0]            rs2_value_o,
  output logic [TAG_W-1:0]           rd_tag_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;

  iq_entry_t         q_q [DEPTH];
  iq_entry_t         q_d [DEPTH];
  iq_entry_t         ext [DEPTH+1];
  src_operand_t      w_src1 [DEPTH];
  src_operand_t      w_src2 [DEPTH];
  src_operand_t      disp_src1, disp_src2, disp_w1, disp_w2;

  logic [CW-1:0]     count_q, count_d;
  logic              ready_q;
  logic              sel_valid;
  logic [IW-1:0]     sel_idx;
  logic [IW-1:0]     wr_idx;
  logic              accept, bypass, store;

  logic              req_q, req_d;
  logic [XLEN-1:0]   pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [TAG_W-1:0]  rd_q, rd_d;

  // Wakeup for every stored operand and for both dispatch operands.
  for (genvar g = 0; g < DEPTH; g++) begin : g_wake
    iq_operand_wakeup u_src1 (
      .op_i(q_q[g].src1), .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i),
      .cdb_value_i(cdb_value_i), .op_o(w_src1[g]));
    iq_operand_wakeup u_src2 (
      .op_i(q_q[g].src2), .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i),
      .cdb_value_i(cdb_value_i), .op_o(w_src2[g]));
  end

  assign disp_src1 = {dispatch_rs1_ready_i, dispatch_rs1_tag_i, dispatch_rs1_value_i};
  assign disp_src2 = {dispatch_rs2_ready_i, dispatch_rs2_tag_i, dispatch_rs2_value_i};

  iq_operand_wakeup u_disp1 (
    .op_i(disp_src1), .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i),
    .cdb_value_i(cdb_value_i), .op_o(disp_w1));
  iq_operand_wakeup u_disp2 (
    .op_i(disp_src2), .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i),
    .cdb_value_i(cdb_value_i), .op_o(disp_w2));

  assign accept = dispatch_valid_i && ready_q;

`ifdef ARITH_IQ_BYPASS_EN
  assign bypass = accept && (count_q == '0) && disp_w1.ready && disp_w2.ready;
`else
  assign bypass = 1'b0;
`endif

  assign store = accept && !bypass;

  // Oldest-ready select uses registered ready flags only (same-edge wakeups wait).
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (q_q[i].valid && q_q[i].src1.ready && q_q[i].src2.ready) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  // Apply wakeups, collapse over the issued slot, then append the new dispatch.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ext[i]      = q_q[i];
      ext[i].src1 = w_src1[i];
      ext[i].src2 = w_src2[i];
    end
    ext[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      q_d[i] = (sel_valid && (IW'(i) >= sel_idx)) ? ext[i+1] : ext[i];
    end
    wr_idx = IW'(count_q - CW'(sel_valid));
    if (store) begin
      q_d[wr_idx].valid  = 1'b1;
      q_d[wr_idx].pc     = dispatch_pc_i;
      q_d[wr_idx].inst   = dispatch_inst_i;
      q_d[wr_idx].rd_tag = dispatch_rd_tag_i;
      q_d[wr_idx].src1   = disp_w1;
      q_d[wr_idx].src2   = disp_w2;
    end
    count_d = count_q + CW'(store) - CW'(sel_valid);
  end

  // Issue output next-state; data holds when nothing issues.
  always_comb begin
    req_d  = 1'b0;
    pc_d   = pc_q;
    inst_d = inst_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    rd_d   = rd_q;
    if (bypass) begin
      req_d  = 1'b1;
      pc_d   = dispatch_pc_i;
      inst_d = dispatch_inst_i;
      rs1_d  = disp_w1.value;
      rs2_d  = disp_w2.value;
      rd_d   = dispatch_rd_tag_i;
    end else if (sel_valid) begin
      req_d  = 1'b1;
      pc_d   = q_q[sel_idx].pc;
      inst_d = q_q[sel_idx].inst;
      rs1_d  = q_q[sel_idx].src1.value;
      rs2_d  = q_q[sel_idx].src2.value;
      rd_d   = q_q[sel_idx].rd_tag;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q     <= '{default: '0};
      count_q <= '0;
      ready_q <= 1'b1;
      req_q   <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end else if (flush_i) begin
      q_q     <= '{default: '0};
      count_q <= '0;
      ready_q <= 1'b1;
      req_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      count_q <= count_d;
      ready_q <= (count_d < CW'(DEPTH));
      req_q   <= req_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
    end
  end

  assign dispatch_ready_o = ready_q;
  assign count_o          = count_q;
  assign arith_request_o  = req_q;
  assign pc_o             = pc_q;
  assign inst_o           = inst_q;
  assign rs1_value_o      = rs1_q;
  assign rs2_value_o      = rs2_q;
  assign rd_tag_o         = rd_q;

endmodule

// File: tb/tb_arith_issue_queue.sv
// Self-checking bench for arith_issue_queue: scenario tasks with inline
// timing checks plus a scoreboard that checks every issued instruction.
module tb_arith_issue_queue;
  import ooo_pkg::*;

  logic              clk_i = 1'b0;
  logic              reset_i, flush_i;
  logic              dispatch_valid_i, dispatch_ready_o;
  logic [XLEN-1:0]   dispatch_pc_i;
  logic [31:0]       dispatch_inst_i;
  logic              dispatch_rs1_ready_i, dispatch_rs2_ready_i;
  logic [TAG_W-1:0]  dispatch_rs1_tag_i, dispatch_rs2_tag_i, dispatch_rd_tag_i;
  logic [XLEN-1:0]   dispatch_rs1_value_i, dispatch_rs2_value_i;
  logic              cdb_valid_i;
  logic [TAG_W-1:0]  cdb_tag_i;
  logic [XLEN-1:0]   cdb_value_i;
  logic              arith_request_o;
  logic [XLEN-1:0]   pc_o, rs1_value_o, rs2_value_o;
  logic [31:0]       inst_o;
  logic [TAG_W-1:0]  rd_tag_o;
  logic [2:0]        count_o;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [31:0]      inst;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [TAG_W-1:0] rd;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  arith_issue_queue #(.DEPTH(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .dispatch_valid_i(dispatch_valid_i), .dispatch_ready_o(dispatch_ready_o),
    .dispatch_pc_i(dispatch_pc_i), .dispatch_inst_i(dispatch_inst_i),
    .dispatch_rs1_ready_i(dispatch_rs1_ready_i), .dispatch_rs1_tag_i(dispatch_rs1_tag_i),
    .dispatch_rs1_value_i(dispatch_rs1_value_i),
    .dispatch_rs2_ready_i(dispatch_rs2_ready_i), .dispatch_rs2_tag_i(dispatch_rs2_tag_i),
    .dispatch_rs2_value_i(dispatch_rs2_value_i),
    .dispatch_rd_tag_i(dispatch_rd_tag_i),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_value_i(cdb_value_i),
    .arith_request_o(arith_request_o), .pc_o(pc_o), .inst_o(inst_o),
    .rs1_value_o(rs1_value_o), .rs2_value_o(rs2_value_o), .rd_tag_o(rd_tag_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard: every issue pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (!reset_i && arith_request_o) begin
      exp_t e, got;
      got = {pc_o, inst_o, rs1_value_o, rs2_value_o, rd_tag_o};
      total_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected_issue: got pc=%h inst=%h, required no issue", pc_o, inst_o);
      end else begin
        e = sb.pop_front();
        if (got !== e)
          $display("FAIL sb_issue: got pc=%h inst=%h rs1=%h rs2=%h rd=%0d, required pc=%h inst=%h rs1=%h rs2=%h rd=%0d",
                   pc_o, inst_o, rs1_value_o, rs2_value_o, rd_tag_o,
                   e.pc, e.inst, e.rs1, e.rs2, e.rd);
        else pass_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic clear_inputs();
    flush_i = 1'b0;
    dispatch_valid_i = 1'b0;
    dispatch_pc_i = '0; dispatch_inst_i = '0;
    dispatch_rs1_ready_i = 1'b0; dispatch_rs1_tag_i = '0; dispatch_rs1_value_i = '0;
    dispatch_rs2_ready_i = 1'b0; dispatch_rs2_tag_i = '0; dispatch_rs2_value_i = '0;
    dispatch_rd_tag_i = '0;
    cdb_valid_i = 1'b0; cdb_tag_i = '0; cdb_value_i = '0;
  endtask

  task automatic drive_dispatch(input logic [31:0] pc, input logic [31:0] inst,
                                input logic r1, input logic [TAG_W-1:0] t1, input logic [31:0] v1,
                                input logic r2, input logic [TAG_W-1:0] t2, input logic [31:0] v2,
                                input logic [TAG_W-1:0] rd);
    dispatch_valid_i = 1'b1;
    dispatch_pc_i = pc; dispatch_inst_i = inst;
    dispatch_rs1_ready_i = r1; dispatch_rs1_tag_i = t1; dispatch_rs1_value_i = v1;
    dispatch_rs2_ready_i = r2; dispatch_rs2_tag_i = t2; dispatch_rs2_value_i = v2;
    dispatch_rd_tag_i = rd;
  endtask

  task automatic drive_cdb(input logic [TAG_W-1:0] t, input logic [31:0] v);
    cdb_valid_i = 1'b1; cdb_tag_i = t; cdb_value_i = v;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_i = 1'b1;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    total_cnt++;
    if (arith_request_o !== 1'b0) $display("FAIL reset_req: got %b required 0", arith_request_o);
    else pass_cnt++;
    total_cnt++;
    if (count_o !== 3'd0) $display("FAIL reset_count: got %0d required 0", count_o);
    else pass_cnt++;
    total_cnt++;
    if (dispatch_ready_o !== 1'b1) $display("FAIL reset_ready: got %b required 1", dispatch_ready_o);
    else pass_cnt++;
    total_cnt++;
    if ({pc_o, inst_o, rs1_value_o, rs2_value_o, rd_tag_o} !== '0)
      $display("FAIL reset_data: got pc=%h inst=%h rs1=%h rs2=%h rd=%0d required all 0",
               pc_o, inst_o, rs1_value_o, rs2_value_o, rd_tag_o);
    else pass_cnt++;
  endtask

  task automatic test_basic_issue();
    drive_dispatch(32'h4, 32'h00518093, 1'b1, 6'd0, 32'h2, 1'b1, 6'd0, 32'h0, 6'd5);
    sb.push_back({32'h4, 32'h00518093, 32'h2, 32'h0, 6'd5});
    @(negedge clk_i);
    clear_inputs();
`ifdef ARITH_IQ_BYPASS_EN
    total_cnt++;
    if (arith_request_o !== 1'b1) $display("FAIL basic_req_e0: got %b required 1", arith_request_o);
    else pass_cnt++;
`else
    total_cnt++;
    if (arith_request_o !== 1'b0) $display("FAIL basic_req_e0: got %b required 0", arith_request_o);
    else pass_cnt++;
    total_cnt++;
    if (count_o !== 3'd1) $display("FAIL basic_count_e0: got %0d required 1", count_o);
    else pass_cnt++;
    @(negedge clk_i);
    total_cnt++;
    if (arith_request_o !== 1'b1) $display("FAIL basic_req_e1: got %b required 1", arith_request_o);
    else pass_cnt++;
`endif
    @(negedge clk_i);
    total_cnt++;
    if (arith_request_o !== 1'b0) $display("FAIL basic_pulse_width: got %b required 0", arith_request_o);
    else pass_cnt++;
  endtask

  task automatic test_cdb_wakeup();
    drive_dispatch(32'h8, 32'h002081b3, 1'b0, 6'd9, 32'h0, 1'b1, 6'd0, 32'h7, 6'd10);
    @(negedge clk_i);
    clear_inputs();
    @(negedge clk_i);
    total_cnt++;
    if (arith_request_o !== 1'b0) $display("FAIL wake_premature: got %b required 0", arith_request_o);
    else pass_cnt++;
    drive_cdb(6'd9, 32'h1234);
    sb.push_back({32'h8, 32'h002081b3, 32'h1234, 32'h7, 6'd10});
    @(negedge clk_i);
    clear_inputs();
    total_cnt++;
    if (arith_request_o !== 1'b0) $display("FAIL wake_same_edge: got %b required 0", arith_request_o);
    else pass_cnt++;
    @(negedge clk_i);
    total_cnt++;
    if (arith_request_o !== 1'b1 || rs1_value_o !== 32'h1234)
      $display("FAIL wake_issue: got req=%b rs1=%h required req=1 rs1=00001234", arith_request_o, rs1_value_o);
    else pass_cnt++;
    @(negedge clk_i);
  endtask

  task automatic test_oldest_ready();
    drive_dispatch(32'h10, 32'h00000033, 1'b0, 6'd3, 32'h0, 1'b1, 6'd0, 32'h5, 6'd11);
    @(negedge clk_i);
    drive_dispatch(32'h14, 32'h00000013, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2, 6'd12);
    sb.push_back({32'h14, 32'h00000013, 32'h1, 32'h2, 6'd12});
    @(negedge clk_i);
    clear_inputs();
    @(negedge clk_i);
    total_cnt++;
    if (arith_request_o !== 1'b1 || pc_o !== 32'h14 || count_o !== 3'd1)
      $display("FAIL order_b_first: got req=%b pc=%h count=%0d required req=1 pc=00000014 count=1",
               arith_request_o, pc_o, count_o);
    else pass_cnt++;
    drive_cdb(6'd3, 32'h33);
    sb.push_back({32'h10, 32'h00000033, 32'h33, 32'h5, 6'd11});
    @(negedge clk_i);
    clear_inputs();
    @(negedge clk_i);
    total_cnt++;
    if (arith_request_o !== 1'b1 || pc_o !== 32'h10 || count_o !== 3'd0)
      $display("FAIL order_a_second: got req=%b pc=%h count=%0d required req=1 pc=00000010 count=0",
               arith_request_o, pc_o, count_o);
    else pass_cnt++;
    @(negedge clk_i);
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive_dispatch(32'h20 + 32'(4 * i), 32'h100 + 32'(i), 1'b0, 6'(10 + i), 32'h0,
                     1'b1, 6'd0, 32'(i), 6'(20 + i));
      @(negedge clk_i);
    end
    clear_inputs();
    total_cnt++;
    if (count_o !== 3'd4 || dispatch_ready_o !== 1'b0)
      $display("FAIL full_state: got count=%0d ready=%b required count=4 ready=0", count_o, dispatch_ready_o);
    else pass_cnt++;
    drive_dispatch(32'h99, 32'h999, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 6'd30);
    @(negedge clk_i);
    clear_inputs();
    total_cnt++;
    if (count_o !== 3'd4 || arith_request_o !== 1'b0)
      $display("FAIL full_reject: got count=%0d req=%b required count=4 req=0", count_o, arith_request_o);
    else pass_cnt++;
    drive_cdb(6'd10, 32'hA0);
    sb.push_back({32'h20, 32'h100, 32'hA0, 32'h0, 6'd20});
    @(negedge clk_i);
    total_cnt++;
    if (dispatch_ready_o !== 1'b0 || arith_request_o !== 1'b0)
      $display("FAIL full_wake_edge: got ready=%b req=%b required ready=0 req=0", dispatch_ready_o, arith_request_o);
    else pass_cnt++;
    for (int i = 1; i < 4; i++) begin
      drive_cdb(6'(10 + i), 32'hA0 + 32'(i));
      sb.push_back({32'h20 + 32'(4 * i), 32'h100 + 32'(i), 32'hA0 + 32'(i), 32'(i), 6'(20 + i)});
      @(negedge clk_i);
      if (i == 1) begin
        total_cnt++;
        if (arith_request_o !== 1'b1 || dispatch_ready_o !== 1'b1 || count_o !== 3'd3)
          $display("FAIL full_ready_restore: got req=%b ready=%b count=%0d required req=1 ready=1 count=3",
                   arith_request_o, dispatch_ready_o, count_o);
        else pass_cnt++;
      end
    end
    clear_inputs();
    for (int k = 0; k < 10 && (count_o != 3'd0 || arith_request_o); k++) @(negedge clk_i);
    total_cnt++;
    if (count_o !== 3'd0 || arith_request_o !== 1'b0)
      $display("FAIL full_drain: got count=%0d req=%b required count=0 req=0", count_o, arith_request_o);
    else pass_cnt++;
  endtask

  task automatic test_same_cycle_cdb();
    drive_dispatch(32'h40, 32'h003100b3, 1'b1, 6'd0, 32'h11, 1'b0, 6'd20, 32'h0, 6'd21);
    drive_cdb(6'd20, 32'hBEEF);
    sb.push_back({32'h40, 32'h003100b3, 32'h11, 32'hBEEF, 6'd21});
    @(negedge clk_i);
    clear_inputs();
`ifndef ARITH_IQ_BYPASS_EN
    total_cnt++;
    if (arith_request_o !== 1'b0) $display("FAIL samecdb_e0: got %b required 0", arith_request_o);
    else pass_cnt++;
    @(negedge clk_i);
`endif
    total_cnt++;
    if (arith_request_o !== 1'b1 || rs2_value_o !== 32'hBEEF)
      $display("FAIL samecdb_issue: got req=%b rs2=%h required req=1 rs2=0000beef", arith_request_o, rs2_value_o);
    else pass_cnt++;
    @(negedge clk_i);
  endtask

  task automatic test_flush();
    drive_dispatch(32'h60, 32'h600, 1'b0, 6'd30, 32'h0, 1'b1, 6'd0, 32'h0, 6'd1);
    @(negedge clk_i);
    drive_dispatch(32'h64, 32'h604, 1'b0, 6'd31, 32'h0, 1'b1, 6'd0, 32'h0, 6'd2);
    @(negedge clk_i);
    drive_dispatch(32'h68, 32'h608, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2, 6'd3);
    @(negedge clk_i);
    total_cnt++;
    if (count_o !== 3'd3) $display("FAIL flush_setup_count: got %0d required 3", count_o);
    else pass_cnt++;
    drive_dispatch(32'h77, 32'h777, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 6'd4);
    flush_i = 1'b1;
    @(negedge clk_i);
    clear_inputs();
    total_cnt++;
    if (arith_request_o !== 1'b0 || count_o !== 3'd0 || dispatch_ready_o !== 1'b1)
      $display("FAIL flush_state: got req=%b count=%0d ready=%b required req=0 count=0 ready=1",
               arith_request_o, count_o, dispatch_ready_o);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      if (k < 2) drive_cdb(6'(30 + k), 32'hF0);
      else clear_inputs();
      @(negedge clk_i);
      total_cnt++;
      if (arith_request_o !== 1'b0 || count_o !== 3'd0)
        $display("FAIL flush_quiet_%0d: got req=%b count=%0d required req=0 count=0", k, arith_request_o, count_o);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    drive_dispatch(32'h80, 32'h800, 1'b0, 6'd40, 32'h0, 1'b1, 6'd0, 32'h0, 6'd7);
    @(negedge clk_i);
    clear_inputs();
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    total_cnt++;
    if ({pc_o, inst_o, rs1_value_o, rs2_value_o, rd_tag_o} !== '0 || count_o !== 3'd0 || arith_request_o !== 1'b0)
      $display("FAIL reset_mid: got pc=%h inst=%h count=%0d req=%b required all 0",
               pc_o, inst_o, count_o, arith_request_o);
    else pass_cnt++;
    total_cnt++;
    if (sb.size() != 0) $display("FAIL sb_leftover: got %0d pending required 0", sb.size());
    else pass_cnt++;
  endtask

  initial begin
    clear_inputs();
    reset_i = 1'b1;
    test_reset();
    test_basic_issue();
    test_cdb_wakeup();
    test_oldest_ready();
    test_full();
    test_same_cycle_cdb();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/arith_issue_queue.md
Name: arith_issue_queue

Overview:
- Reservation station that feeds the arith execution unit. It is the initiator side of the arith request interface (arith_request, pc, inst, rs1_value, rs2_value).
- Holds dispatched ALU instructions until both source operands are ready. Captures operands from the common data bus (CDB).
- Issues at most one instruction per cycle, always the oldest ready entry. Sits between rename/dispatch and the arith unit.

Parameters:
- DEPTH, 4, number of queue entries (power of 2, at least 2).
- TAG_W, 6, physical register tag width.
- XLEN, 32, datapath width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all entries and any pending issue.
- dispatch_valid_i  in  1  dispatch request.
- dispatch_ready_o  out  1  queue can accept this cycle.
- dispatch_pc_i  in  XLEN  instruction PC.
- dispatch_inst_i  in  32  raw instruction.
- dispatch_rs1_ready_i  in  1  rs1 value already valid.
- dispatch_rs1_tag_i  in  TAG_W  rs1 producer tag.
- dispatch_rs1_value_i  in  XLEN  rs1 value (used when ready).
- dispatch_rs2_ready_i / dispatch_rs2_tag_i / dispatch_rs2_value_i  in  1/TAG_W/XLEN  same for rs2.
- dispatch_rd_tag_i  in  TAG_W  destination tag.
- cdb_valid_i  in  1  writeback broadcast valid.
- cdb_tag_i  in  TAG_W  broadcast tag.
- cdb_value_i  in  XLEN  broadcast value.
- arith_request_o  out  1  issue strobe to arith unit.
- pc_o  out  XLEN  issued PC.
- inst_o  out  32  issued instruction.
- rs1_value_o  out  XLEN  issued rs1 operand.
- rs2_value_o  out  XLEN  issued rs2 operand.
- rd_tag_o  out  TAG_W  issued destination tag.
- count_o  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset: clears all entry valid bits. arith_request_o=0, count_o=0, pc_o/inst_o/rs1_value_o/rs2_value_o/rd_tag_o=0, dispatch_ready_o=1 the cycle after reset.
- Storage: collapsing queue; index 0 is the oldest. Per entry: valid, pc, inst, rd_tag, and for each operand {ready, tag, value}.
- Handshake: dispatch accepted on a posedge with dispatch_valid_i & dispatch_ready_o.
- dispatch_ready_o = (count_o < DEPTH), from registered count. No same-cycle credit from an issue, so a full queue rejects dispatch even if it issues that edge.
- Wakeup: each posedge, every valid entry operand with ready=0 and tag==cdb_tag_i (cdb_valid_i=1) sets ready=1 and captures cdb_value_i.
- The same match applies to a dispatching instruction's operands. A CDB hit in the dispatch cycle must not be lost.
- Select: on each posedge, the lowest-index entry with both ready flags registered high is chosen. Wakeups in the same edge do not count, so a woken entry issues at the next edge at the earliest.
- Issue outputs are registered. On select: arith_request_o<=1 and the entry fields are loaded into the outputs. With no selection: arith_request_o<=0 and the data outputs hold.
- arith_request_o is a single-cycle pulse per instruction. The arith unit never stalls; no back-pressure.
- Latency (bypass off): dispatch at edge E0 with both operands ready gives arith_request_o high after E1 (2-cycle dispatch-to-request).
- Collapse: an issued entry at index k is removed; entries k+1..count-1 shift down one. The new dispatch is written at index count_o minus 1 if issuing, else at count_o.
- Shifted entries keep any wakeup applied that same edge.
- count_o: next = count + accepted - issued.
- Flush: has priority over dispatch, wakeup and select. At the next edge all entries are invalid, count_o=0, arith_request_o=0.
- Reset asserted mid-operation behaves identically to flush and also clears the data outputs.
- dispatch_valid_i with dispatch_ready_o=0: no state change.

Optional Feature:
- Macro: ARITH_IQ_BYPASS_EN.
- Defined: when the queue is empty (count_o=0) and the dispatched instruction has both operands ready (flags or same-edge CDB hit), it is loaded straight into the issue outputs at edge E0 and never enters storage. This gives 1-cycle latency and count_o stays 0.
- Undefined: every dispatch enters storage; 2-cycle minimum latency.

Decomposition:
- Shared package (ooo_pkg): TAG_W and XLEN constants, and the typedef iq_entry_t {valid, pc, inst, rd_tag, src1, src2}.
- Also in the package: typedef src_operand_t {ready, tag, value}.
- One sub-module: iq_operand_wakeup. It is combinational: takes a src_operand_t plus the CDB inputs and returns the updated operand. It is instantiated per stored operand and for the two dispatch operands.

Test Plan:
- Reset, then dispatch inst 0x00518093 (addi x1,x3,5), pc 0x4, rs1 ready value 0x2, rs2 ready 0x0, rd_tag 5. Required: arith_request_o high exactly one cycle, 2 cycles after dispatch edge, with pc_o=0x4, inst_o=0x00518093, rs1_value_o=0x2, rd_tag_o=5. With bypass: 1 cycle after.
- Dispatch with rs1 not ready, tag 9. Two cycles later drive CDB tag 9, value 0x1234. Required: arith_request_o the edge after the CDB edge, with rs1_value_o=0x1234.
- Dispatch A (waiting on tag 3) then B (ready). Required: B issues first. After CDB tag 3, A issues, proving oldest-ready selection and collapse correctness.
- Fill 4 non-ready entries. Required: dispatch_ready_o=0, count_o=4, and a 5th dispatch_valid_i is ignored. A CDB wakeup of entry 0 restores ready one edge after it issues.
- Dispatch with CDB tag matching rs2 in the same cycle. Required: value captured and issue without a further CDB.
- With 3 valid entries and a ready one selected, assert flush_i together with dispatch_valid_i. Required: arith_request_o=0, count_o=0 next cycle, nothing issued afterward.
